// File: rtl/branch_pkg.sv
// Shared opcode constants and resolver FSM states for the branch_resolve block.
package branch_pkg;

  localparam logic [3:0] OP_BNE = 4'b0001;
  localparam logic [3:0] OP_BEQ = 4'b0010;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

endpackage

// File: rtl/branch_resolve_lane_compare.sv
// Per-lane branch condition evaluator: purely combinational taken flag.
module lane_compare
  import branch_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [3:0]            op,
  input  logic [DATA_WIDTH-1:0] data1,
  input  logic [DATA_WIDTH-1:0] data2,
  output logic                  taken
);

  always_comb begin
    taken = 1'b0;
    case (op)
      OP_BNE:  taken = (data1 != data2);
      OP_BEQ:  taken = (data1 == data2);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// Resolves an issue group of branches (predicted not-taken), redirects on the oldest
// taken lane and blocks input while the pipe flushes. BRANCH_RESOLVE_STATS_EN adds a mispredict counter.
module branch_resolve
  import branch_pkg::*;
#(
  parameter int LANES        = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES*4-1:0]            in_op,
  input  logic [LANES*DATA_WIDTH-1:0]   in_data1,
  input  logic [LANES*DATA_WIDTH-1:0]   in_data2,
  input  logic [LANES*ADDR_WIDTH-1:0]   in_target,
  output logic                          redirect_valid,
  output logic [ADDR_WIDTH-1:0]         redirect_pc,
  output logic [$clog2(LANES)-1:0]      redirect_lane,
  output logic [LANES-1:0]              flush_mask
`ifdef BRANCH_RESOLVE_STATS_EN
  ,
  output logic [15:0]                   mispredict_count
`endif
);

  localparam int LANE_W = $clog2(LANES);

  logic [LANES-1:0]      taken_vec;
  logic                  win_any;
  logic [LANE_W-1:0]     win_lane;
  logic [ADDR_WIDTH-1:0] win_target;
  logic                  accept;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  valid_q, valid_d;
  logic [LANE_W-1:0]     lane_q, lane_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    lane_compare #(.DATA_WIDTH(DATA_WIDTH)) u_cmp (
      .op    (in_op[gi*4 +: 4]),
      .data1 (in_data1[gi*DATA_WIDTH +: DATA_WIDTH]),
      .data2 (in_data2[gi*DATA_WIDTH +: DATA_WIDTH]),
      .taken (taken_vec[gi])
    );
  end

  // Scan from youngest to oldest so the oldest taken lane is the last write.
  always_comb begin
    win_any    = 1'b0;
    win_lane   = '0;
    win_target = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (taken_vec[i]) begin
        win_any    = 1'b1;
        win_lane   = LANE_W'(i);
        win_target = in_target[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  assign in_ready       = rst || (state_q == ST_IDLE);
  assign accept         = in_valid && in_ready && !rst;
  assign redirect_valid = valid_q && !rst;
  assign redirect_pc    = redirect_valid ? pc_q : '0;
  assign redirect_lane  = redirect_valid ? lane_q : '0;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_mask
    assign flush_mask[gi] = redirect_valid && (LANE_W'(gi) > lane_q);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    lane_d  = lane_q;
    pc_d    = pc_q;
    case (state_q)
      ST_IDLE: begin
        if (redirect_valid) begin
          state_d = ST_FLUSH;
          cnt_d   = 4'(FLUSH_CYCLES);
        end
      end
      ST_FLUSH: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A group arriving alongside a redirect is on the wrong path and never fires.
    if (accept) begin
      valid_d = win_any && !redirect_valid;
      lane_d  = win_lane;
      pc_d    = win_target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      valid_q <= 1'b0;
      lane_q  <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      lane_q  <= lane_d;
      pc_q    <= pc_d;
    end
  end

`ifdef BRANCH_RESOLVE_STATS_EN
  logic [15:0] stat_q, stat_d;

  always_comb begin
    stat_d = stat_q;
    if (redirect_valid && (stat_q != 16'hFFFF)) stat_d = stat_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) stat_q <= 16'd0;
    else     stat_q <= stat_d;
  end

  assign mispredict_count = rst ? 16'd0 : stat_q;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve with a cycle-level behavioural model and per-cycle compare.
module tb_branch_resolve;

  localparam int LANES = 4;
  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int FC    = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [LANES*4-1:0]  in_op;
  logic [LANES*DW-1:0] in_data1;
  logic [LANES*DW-1:0] in_data2;
  logic [LANES*AW-1:0] in_target;
  logic              redirect_valid;
  logic [AW-1:0]     redirect_pc;
  logic [1:0]        redirect_lane;
  logic [LANES-1:0]  flush_mask;
`ifdef BRANCH_RESOLVE_STATS_EN
  logic [15:0]       mispredict_count;
`endif

  int checks = 0;
  int errors = 0;

  branch_resolve #(.LANES(LANES), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FLUSH_CYCLES(FC)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_op          (in_op),
    .in_data1       (in_data1),
    .in_data2       (in_data2),
    .in_target      (in_target),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_lane  (redirect_lane),
    .flush_mask     (flush_mask)
`ifdef BRANCH_RESOLVE_STATS_EN
    ,
    .mispredict_count (mispredict_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: redirect info for the cycle after an accepted group,
  // plus a count of remaining blocked cycles.
  logic        m_rv   = 1'b0;
  logic [31:0] m_pc   = '0;
  int          m_lane = 0;
  logic [3:0]  m_mask = '0;
  int          blk    = 0;
  logic [15:0] m_cnt  = '0;

  function automatic bit m_taken(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op == 4'd1) return (a != b);
    if (op == 4'd2) return (a == b);
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    bit acc;
    bit was;
    if (rst) begin
      m_rv = 0; m_pc = 0; m_lane = 0; m_mask = 0; blk = 0; m_cnt = 0;
    end else begin
      acc = in_valid && (blk == 0);
      was = m_rv;
      if (was) begin
        blk = FC;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end else if (blk > 0) begin
        blk = blk - 1;
      end
      m_rv = 0; m_pc = 0; m_lane = 0; m_mask = 0;
      if (acc && !was) begin
        for (int i = 0; i < LANES; i++) begin
          if (!m_rv && m_taken(in_op[i*4 +: 4], in_data1[i*DW +: DW], in_data2[i*DW +: DW])) begin
            m_rv   = 1;
            m_lane = i;
            m_pc   = in_target[i*AW +: AW];
            m_mask = 4'((32'd1 << LANES) - 1) & ~4'((32'd2 << i) - 1);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    check("m_ready", {31'd0, in_ready}, {31'd0, rst || (blk == 0)});
    check("m_rv", {31'd0, redirect_valid}, {31'd0, !rst && m_rv});
    check("m_pc", redirect_pc, (!rst && m_rv) ? m_pc : 32'd0);
    check("m_lane", {30'd0, redirect_lane}, (!rst && m_rv) ? m_lane : 0);
    check("m_mask", {28'd0, flush_mask}, (!rst && m_rv) ? {28'd0, m_mask} : 32'd0);
`ifdef BRANCH_RESOLVE_STATS_EN
    check("m_count", {16'd0, mispredict_count}, rst ? 32'd0 : {16'd0, m_cnt});
`endif
  end

  task automatic clr();
    in_valid = 0; in_op = '0; in_data1 = '0; in_data2 = '0; in_target = '0;
  endtask

  task automatic set_lane(input int i, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] t);
    in_op[i*4 +: 4]     = op;
    in_data1[i*DW +: DW] = a;
    in_data2[i*DW +: DW] = b;
    in_target[i*AW +: AW] = t;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr();
    rst = 1;
    // Group presented during reset must never be accepted.
    set_lane(0, 4'b0001, 1, 2, 32'hDEAD_0000);
    in_valid = 1;
    @(negedge clk);
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    check("rst_rv", {31'd0, redirect_valid}, 32'd0);
    tick(); tick();
    rst = 0; clr();
    @(negedge clk);
    check("post_rst_rv", {31'd0, redirect_valid}, 32'd0);
    check("post_rst_ready", {31'd0, in_ready}, 32'd1);
    check("post_rst_pc", redirect_pc, 32'd0);
    check("post_rst_mask", {28'd0, flush_mask}, 32'd0);

    // Lane 1 BNE 5 vs 7
    tick(); clr();
    set_lane(1, 4'b0001, 5, 7, 32'h1000_0100);
    in_valid = 1;
    @(negedge clk);
    check("t1_ready_pre", {31'd0, in_ready}, 32'd1);
    tick(); clr();
    @(negedge clk);
    check("t1_rv", {31'd0, redirect_valid}, 32'd1);
    check("t1_lane", {30'd0, redirect_lane}, 32'd1);
    check("t1_mask", {28'd0, flush_mask}, 32'hC);
    check("t1_pc", redirect_pc, 32'h1000_0100);
    @(negedge clk); check("t1_block0", {31'd0, in_ready}, 32'd0);
    @(negedge clk); check("t1_block1", {31'd0, in_ready}, 32'd0);
    @(negedge clk); check("t1_release", {31'd0, in_ready}, 32'd1);

    // Lane 0 BEQ 3==3 beats lane 2 BNE 1!=2
    tick(); clr();
    set_lane(0, 4'b0010, 3, 3, 32'h2000_0000);
    set_lane(2, 4'b0001, 1, 2, 32'h2000_0200);
    in_valid = 1;
    tick(); clr();
    @(negedge clk);
    check("t2_rv", {31'd0, redirect_valid}, 32'd1);
    check("t2_lane", {30'd0, redirect_lane}, 32'd0);
    check("t2_mask", {28'd0, flush_mask}, 32'hE);
    check("t2_pc", redirect_pc, 32'h2000_0000);
    repeat (3) @(negedge clk);
    check("t2_release", {31'd0, in_ready}, 32'd1);

    // Four back-to-back not-taken BNE groups
    for (int k = 0; k < 4; k++) begin
      tick(); clr();
      for (int i = 0; i < LANES; i++) set_lane(i, 4'b0001, k + i, k + i, 32'h3000_0000 + i);
      in_valid = 1;
      @(negedge clk);
      check("t3_ready", {31'd0, in_ready}, 32'd1);
      check("t3_rv", {31'd0, redirect_valid}, 32'd0);
    end
    tick(); clr();
    @(negedge clk);
    check("t3_rv_end", {31'd0, redirect_valid}, 32'd0);

    // Taken group in lane 3, then an immediately following taken group
    tick(); clr();
    set_lane(3, 4'b0001, 0, 1, 32'h4000_0300);
    in_valid = 1;
    tick(); clr();
    set_lane(0, 4'b0010, 9, 9, 32'h4000_0000);
    in_valid = 1;
    @(negedge clk);
    check("t4_rv", {31'd0, redirect_valid}, 32'd1);
    check("t4_lane", {30'd0, redirect_lane}, 32'd3);
    check("t4_mask", {28'd0, flush_mask}, 32'd0);
    check("t4_pc", redirect_pc, 32'h4000_0300);
    check("t4_ready", {31'd0, in_ready}, 32'd1);
    tick(); clr();
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      check("t4_discard", {31'd0, redirect_valid}, 32'd0);
    end

    // Reset during the second flush cycle
    tick(); clr();
    set_lane(1, 4'b0001, 1, 0, 32'h5000_0100);
    in_valid = 1;
    tick(); clr();
    tick();
    @(negedge clk);
    check("t5_flush", {31'd0, in_ready}, 32'd0);
    tick();
    rst = 1;
    @(negedge clk);
    check("t5_rst_ready", {31'd0, in_ready}, 32'd1);
    tick();
    rst = 0;
    @(negedge clk);
    check("t5_idle", {31'd0, in_ready}, 32'd1);

    // Reset during the first flush cycle aborts the flush
    tick(); clr();
    set_lane(2, 4'b0010, 7, 7, 32'h6000_0200);
    in_valid = 1;
    tick(); clr();
    tick();
    rst = 1;
    @(negedge clk);
    check("t6_rst_ready", {31'd0, in_ready}, 32'd1);
    tick();
    rst = 0;
    @(negedge clk);
    check("t6_abort", {31'd0, in_ready}, 32'd1);

`ifdef BRANCH_RESOLVE_STATS_EN
    for (int r = 0; r < 3; r++) begin
      tick(); clr();
      set_lane(2, 4'b0010, 4, 4, 32'h7000_0000);
      in_valid = 1;
      tick(); clr();
      repeat (3) tick();
    end
    @(negedge clk);
    check("t7_count3", {16'd0, mispredict_count}, 32'd3);
    tick();
    dut.stat_q = 16'hFFFE;
    m_cnt = 16'hFFFE;
    for (int r = 0; r < 3; r++) begin
      tick(); clr();
      set_lane(0, 4'b0001, 1, 2, 32'h7100_0000);
      in_valid = 1;
      tick(); clr();
      repeat (3) tick();
    end
    @(negedge clk);
    check("t7_sat", {16'd0, mispredict_count}, 32'h0000_FFFF);
`endif

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 Parameter LANES, default 4: number of instruction lanes per issue group; lane 0 is the oldest.
REQ-002 Parameter DATA_WIDTH, default 32: width of each compared operand.
REQ-003 Parameter ADDR_WIDTH, default 32: width of the branch target address.
REQ-004 Parameter FLUSH_CYCLES, default 2, legal range 1..15: number of cycles input is blocked after a redirect.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 in_valid  in  1  issue group is presented this cycle.
REQ-008 in_ready  out  1  block accepts the group; a group transfers when in_valid && in_ready.
REQ-009 in_op  in  LANES*4  per-lane opcode: 4'b0001 = BNE, 4'b0010 = BEQ, all others are non-branch.
REQ-010 in_data1, in_data2  in  LANES*DATA_WIDTH each  per-lane source operands.
REQ-011 in_target  in  LANES*ADDR_WIDTH  per-lane branch target.
REQ-012 redirect_valid  out  1  one-cycle pulse: a taken (mispredicted) branch was resolved.
REQ-013 redirect_pc  out  ADDR_WIDTH  target of the winning branch; valid only with redirect_valid.
REQ-014 redirect_lane  out  $clog2(LANES)  index of the winning lane.
REQ-015 flush_mask  out  LANES  lanes younger than the winner, to be killed; valid only with redirect_valid.
REQ-016 mispredict_count  out  16  saturating count of redirects; present only under the macro in REQ-034.

Function
REQ-017 Branch prediction is not-taken, so every taken branch is a mispredict.
REQ-018 BNE is taken when data1 != data2; BEQ is taken when data1 == data2; non-branch lanes are never taken.
REQ-019 Latency is 1 cycle: taken flags, targets and lane index are registered on accept, and redirect_* drive from those registers on the next cycle.
REQ-020 Winner selection: the lowest-indexed taken lane wins, and later taken lanes in the same group are ignored.
REQ-021 flush_mask[i] = 1 exactly for i > winner; a winner in lane LANES-1 gives flush_mask = 0.
REQ-022 A group with no taken lane produces no redirect_valid, and redirect_pc, redirect_lane and flush_mask are 0.
REQ-023 FSM states: IDLE and FLUSH.
REQ-024 IDLE: in_ready = 1; the FSM enters FLUSH in the cycle redirect_valid = 1.
REQ-025 FLUSH: in_ready = 0; a down-counter is loaded with FLUSH_CYCLES on entry, and the FSM returns to IDLE after FLUSH_CYCLES cycles in FLUSH.
REQ-026 A group accepted in the same cycle redirect_valid pulses belongs to the wrong path and is discarded: its registered flags are cleared and it can never redirect.
REQ-027 Back-to-back groups with no taken branch are accepted every cycle at full throughput.
REQ-028 in_valid = 0 produces no state change beyond the FSM counter.

Reset
REQ-029 On rst = 1 at a clock edge, the following are set regardless of current state, including mid-FLUSH: FSM = IDLE, counter = 0, all registered flags = 0.
REQ-030 Output values while and immediately after reset: in_ready = 1, redirect_valid = 0, redirect_pc = 0, redirect_lane = 0, flush_mask = 0, mispredict_count = 0.
REQ-031 A group presented in the reset cycle is not accepted.

Configuration
REQ-032 The macro BRANCH_RESOLVE_STATS_EN controls the mispredict statistics counter.
REQ-033 Without BRANCH_RESOLVE_STATS_EN, the mispredict_count port and its counter do not exist.
REQ-034 With BRANCH_RESOLVE_STATS_EN, mispredict_count increments by 1 on each redirect_valid pulse and saturates at 16'hFFFF.

Structure
REQ-035 Package branch_pkg holds the opcode constants (OP_BNE = 4'b0001, OP_BEQ = 4'b0010) and the FSM state enum.
REQ-036 Sub-module lane_compare (op, data1, data2 -> taken) is combinational and is instantiated LANES times by generate.

Verification
REQ-037 LANES = 4, lane 1 BNE with 5 vs 7, other lanes non-branch -> next cycle: redirect_valid = 1, redirect_lane = 1, flush_mask = 4'b1100, in_ready = 0 for 2 cycles.
REQ-038 Lane 0 BEQ 3 vs 3 and lane 2 BNE 1 vs 2 -> redirect_lane = 0, flush_mask = 4'b1110, and lane 0's target appears on redirect_pc.
REQ-039 4 consecutive groups, all BNE with equal operands -> no redirect_valid, and in_ready stays 1 throughout.
REQ-040 A taken group followed immediately by a second taken group -> exactly one redirect; the second group is discarded.
REQ-041 rst asserted during the second FLUSH cycle -> next cycle in_ready = 1 and the FSM is in IDLE.
REQ-042 With BRANCH_RESOLVE_STATS_EN, 3 redirects -> mispredict_count = 3; with the counter forced near 16'hFFFF, further redirects hold it at 16'hFFFF.
